// File: rtl/clk_ce_pkg.sv
// Shared constants and helpers for the clock-enable generator.
// inc_from_hz turns a target enable rate into a rounded accumulator increment.
package clk_ce_pkg;

  localparam int ACC_W_DEF    = 32;
  localparam int NUM_CH_DEF   = 4;
  localparam int LOCK_CYC_DEF = 16;

  // Channel-select width: at least one bit, even for a single channel.
  function automatic int sel_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // round(out_hz * 2^acc_w / ref_hz), computed in wide integer arithmetic.
  function automatic logic [63:0] inc_from_hz(input longint unsigned ref_hz,
                                              input longint unsigned out_hz,
                                              input int unsigned     acc_w);
    logic [127:0] num;
    logic [127:0] den;
    if (ref_hz == 0) return 64'd0;
    den = {64'd0, ref_hz};
    num = ({64'd0, out_hz} << acc_w) + {64'd0, (ref_hz >> 1)};
    return 64'(num / den);
  endfunction

endpackage

// File: rtl/clk_ce_gen_if.sv
// Control/status bundle of the clock-enable generator.
// master drives run enables, sync and config writes; slave returns the enables.
interface clk_ce_gen_if
  import clk_ce_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int SEL_W  = sel_width(NUM_CH)
);
  logic [NUM_CH-1:0] ch_en;
  logic              sync;
  logic              cfg_we;
  logic [SEL_W-1:0]  cfg_sel;
  logic [ACC_W-1:0]  cfg_inc;
  logic [NUM_CH-1:0] ce;
  logic [NUM_CH-1:0] tgl;
  logic              locked;

  modport master (
    output ch_en, sync, cfg_we, cfg_sel, cfg_inc,
    input  ce, tgl, locked
  );

  modport slave (
    input  ch_en, sync, cfg_we, cfg_sel, cfg_inc,
    output ce, tgl, locked
  );
endinterface

// File: rtl/clk_ce_chan.sv
// One phase-accumulator channel: emits a registered ce pulse on each
// accumulator wrap and a toggle output that flips with every pulse.
module clk_ce_chan
  import clk_ce_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic [ACC_W-1:0] inc,
  input  logic [ACC_W-1:0] phase,
  output logic             ce,
  output logic             tgl
);
  logic [ACC_W-1:0] acc_reg;
  logic             ce_reg;
  logic             tgl_reg;
  logic [ACC_W:0]   sum_next;

  // Carry out of the extra top bit is the wrap indication.
  assign sum_next = {1'b0, acc_reg} + {1'b0, inc};

  always_ff @(posedge refclk) begin
    if (rst) begin
      acc_reg <= phase;
      ce_reg  <= 1'b0;
      tgl_reg <= 1'b0;
    end else if (sync) begin
      acc_reg <= phase;
      ce_reg  <= 1'b0;
    end else if (en) begin
      acc_reg <= sum_next[ACC_W-1:0];
      ce_reg  <= sum_next[ACC_W];
      if (sum_next[ACC_W]) begin
        tgl_reg <= ~tgl_reg;
      end
    end else begin
      ce_reg <= 1'b0;
    end
  end

  assign ce  = ce_reg;
  assign tgl = tgl_reg;

endmodule

// File: rtl/clk_ce_gen.sv
// Multi-channel fractional clock-enable generator: increment register file,
// config decode, lock qualification and one accumulator channel per enable.
module clk_ce_gen
  import clk_ce_pkg::*;
#(
  parameter int                      NUM_CH   = NUM_CH_DEF,
  parameter int                      ACC_W    = ACC_W_DEF,
  parameter logic [NUM_CH*ACC_W-1:0] DEF_INC  = {NUM_CH{1'b1, {(ACC_W-1){1'b0}}}},
  parameter logic [NUM_CH*ACC_W-1:0] PHASE    = '0,
  parameter int                      LOCK_CYC = LOCK_CYC_DEF
) (
  input  logic         refclk,
  input  logic         rst,
  clk_ce_gen_if.slave  bus
);
  localparam int SEL_W = sel_width(NUM_CH);
  localparam int CNT_W = $clog2(LOCK_CYC + 1);

  logic              cfg_valid;
  logic [NUM_CH-1:0] ce_vec;
  logic [NUM_CH-1:0] tgl_vec;
  logic [CNT_W-1:0]  lock_cnt_reg;
  logic              locked_reg;

  // Selects beyond the last channel are dropped and do not disturb lock.
  assign cfg_valid = bus.cfg_we && (32'(bus.cfg_sel) < 32'(NUM_CH));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic             hit;
      logic [ACC_W-1:0] inc_reg;

      assign hit = cfg_valid && (bus.cfg_sel == SEL_W'(gi));

      always_ff @(posedge refclk) begin
        if (rst) begin
          inc_reg <= DEF_INC[gi*ACC_W +: ACC_W];
        end else if (hit) begin
          inc_reg <= bus.cfg_inc;
        end
      end

      clk_ce_chan #(
        .ACC_W (ACC_W)
      ) u_chan (
        .refclk (refclk),
        .rst    (rst),
        .en     (bus.ch_en[gi]),
        .sync   (bus.sync),
        .inc    (inc_reg),
        .phase  (PHASE[gi*ACC_W +: ACC_W]),
        .ce     (ce_vec[gi]),
        .tgl    (tgl_vec[gi])
      );
    end
  endgenerate

  // locked is set on the same edge the counter reaches LOCK_CYC, so it rises
  // on the LOCK_CYC-th edge after reset release or the last accepted write.
  always_ff @(posedge refclk) begin
    if (rst || cfg_valid) begin
      lock_cnt_reg <= '0;
      locked_reg   <= 1'b0;
    end else if (lock_cnt_reg < CNT_W'(LOCK_CYC)) begin
      lock_cnt_reg <= lock_cnt_reg + CNT_W'(1);
      locked_reg   <= (lock_cnt_reg == CNT_W'(LOCK_CYC - 1));
    end else begin
      locked_reg   <= 1'b1;
    end
  end

  assign bus.ce     = ce_vec;
  assign bus.tgl    = tgl_vec;
  assign bus.locked = locked_reg;

endmodule

// File: tb/tb_clk_ce_gen.sv
// Directed bench for clk_ce_gen: a 4-channel instance for rates, sync, run
// enable, config and reset, plus a 3-channel instance for out-of-range selects.
module tb_clk_ce_gen;
  import clk_ce_pkg::*;

  localparam logic [31:0] INC_HALF = 32'(inc_from_hz(64'd100_000_000, 64'd50_000_000, 32));
  localparam logic [31:0] INC_QTR  = 32'(inc_from_hz(64'd100_000_000, 64'd25_000_000, 32));
  localparam logic [31:0] INC_2_5  = 32'h6666_6666;

  logic refclk;
  logic rst;
  int   n_cmp;
  int   n_err;

  clk_ce_gen_if #(.NUM_CH(4), .ACC_W(32)) bus4 ();
  clk_ce_gen_if #(.NUM_CH(3), .ACC_W(32)) bus3 ();

  clk_ce_gen #(
    .NUM_CH   (4),
    .ACC_W    (32),
    .DEF_INC  ({INC_HALF, 32'h0, INC_QTR, INC_HALF}),
    .PHASE    ({32'h0, 32'h0, 32'h8000_0000, 32'h0}),
    .LOCK_CYC (16)
  ) dut (
    .refclk (refclk),
    .rst    (rst),
    .bus    (bus4)
  );

  clk_ce_gen #(
    .NUM_CH   (3),
    .ACC_W    (32),
    .DEF_INC  ({INC_QTR, INC_QTR, INC_HALF}),
    .PHASE    ('0),
    .LOCK_CYC (16)
  ) dut3 (
    .refclk (refclk),
    .rst    (rst),
    .bus    (bus3)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] exp_ce;
    logic [3:0] exp_tgl;
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (bus4.ce !== 4'h0) begin n_err++; $display("FAIL reset_ce got=%h want=0", bus4.ce); end
    n_cmp++; if (bus4.tgl !== 4'h0) begin n_err++; $display("FAIL reset_tgl got=%h want=0", bus4.tgl); end
    n_cmp++; if (bus4.locked !== 1'b0) begin n_err++; $display("FAIL reset_locked got=%b want=0", bus4.locked); end
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_ce  = {(k % 2 == 0), 1'b0, (k % 4 == 2), (k % 2 == 0)};
      exp_tgl = {((k / 2) % 2 == 1), 1'b0, (((k + 2) / 4) % 2 == 1), ((k / 2) % 2 == 1)};
      n_cmp++; if (bus4.ce !== exp_ce) begin n_err++; $display("FAIL dflt_ce edge=%0d got=%h want=%h", k, bus4.ce, exp_ce); end
      n_cmp++; if (bus4.tgl !== exp_tgl) begin n_err++; $display("FAIL dflt_tgl edge=%0d got=%h want=%h", k, bus4.tgl, exp_tgl); end
      n_cmp++; if (bus4.locked !== (k >= 16)) begin n_err++; $display("FAIL dflt_locked edge=%0d got=%b want=%b", k, bus4.locked, (k >= 16)); end
    end
    $display("test_reset: done, %0d compared so far", n_cmp);
  endtask

  task automatic test_cfg_rate();
    int n_pulse;
    int n_bad_gap;
    int last;
    n_pulse   = 0;
    n_bad_gap = 0;
    last      = 0;
    n_cmp++; if (bus4.locked !== 1'b1) begin n_err++; $display("FAIL rate_pre_locked got=%b want=1", bus4.locked); end
    bus4.cfg_we  = 1'b1;
    bus4.cfg_sel = 2'd2;
    bus4.cfg_inc = INC_2_5;
    tick();
    bus4.cfg_we  = 1'b0;
    n_cmp++; if (bus4.locked !== 1'b0) begin n_err++; $display("FAIL rate_unlock got=%b want=0", bus4.locked); end
    for (int j = 1; j <= 1001; j++) begin
      tick();
      if (j == 15) begin
        n_cmp++; if (bus4.locked !== 1'b0) begin n_err++; $display("FAIL rate_lock15 got=%b want=0", bus4.locked); end
      end
      if (j == 16) begin
        n_cmp++; if (bus4.locked !== 1'b1) begin n_err++; $display("FAIL rate_lock16 got=%b want=1", bus4.locked); end
      end
      if (j >= 2 && bus4.ce[2] === 1'b1) begin
        n_pulse++;
        if (last > 0 && (j - last < 2 || j - last > 3)) n_bad_gap++;
        last = j;
      end
    end
    n_cmp++; if (n_pulse !== 400) begin n_err++; $display("FAIL rate_count got=%0d want=400", n_pulse); end
    n_cmp++; if (n_bad_gap !== 0) begin n_err++; $display("FAIL rate_spacing bad_gaps=%0d want=0", n_bad_gap); end
    $display("test_cfg_rate: %0d ce2 pulses in 1000 cycles", n_pulse);
  endtask

  task automatic test_sync();
    logic [3:0] exp_ce [4];
    exp_ce = '{4'b0000, 4'b1011, 4'b0000, 4'b1001};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (37) tick();
    bus4.sync = 1'b1;
    tick();
    bus4.sync = 1'b0;
    n_cmp++; if (bus4.ce !== 4'h0) begin n_err++; $display("FAIL sync_ce got=%h want=0", bus4.ce); end
    n_cmp++; if (bus4.tgl !== 4'b0010) begin n_err++; $display("FAIL sync_tgl got=%h want=2", bus4.tgl); end
    for (int j = 1; j <= 4; j++) begin
      tick();
      n_cmp++; if (bus4.ce !== exp_ce[j-1]) begin n_err++; $display("FAIL sync_after edge=%0d got=%h want=%h", j, bus4.ce, exp_ce[j-1]); end
      if (j == 2) begin
        n_cmp++; if (bus4.tgl !== 4'b1001) begin n_err++; $display("FAIL sync_tgl2 got=%h want=9", bus4.tgl); end
      end
    end
    n_cmp++; if (bus4.tgl !== 4'b0000) begin n_err++; $display("FAIL sync_tgl4 got=%h want=0", bus4.tgl); end
    $display("test_sync: phase reload checked");
  endtask

  task automatic test_ch_en();
    bus4.ch_en = 4'b1101;
    for (int i = 1; i <= 10; i++) begin
      tick();
      n_cmp++; if (bus4.ce[1] !== 1'b0) begin n_err++; $display("FAIL chen_ce1 edge=%0d got=%b want=0", i, bus4.ce[1]); end
      n_cmp++; if (bus4.tgl[1] !== 1'b0) begin n_err++; $display("FAIL chen_tgl1 edge=%0d got=%b want=0", i, bus4.tgl[1]); end
    end
    bus4.ch_en = 4'hF;
    for (int i = 1; i <= 6; i++) begin
      tick();
      n_cmp++; if (bus4.ce[1] !== (i == 2 || i == 6)) begin n_err++; $display("FAIL resume_ce1 edge=%0d got=%b want=%b", i, bus4.ce[1], (i == 2 || i == 6)); end
      n_cmp++; if (bus4.tgl[1] !== (i >= 2 && i < 6)) begin n_err++; $display("FAIL resume_tgl1 edge=%0d got=%b want=%b", i, bus4.tgl[1], (i >= 2 && i < 6)); end
    end
    $display("test_ch_en: freeze and resume checked");
  endtask

  task automatic test_bad_sel();
    int c0;
    int c1;
    int c2;
    int n_unlock;
    c0 = 0; c1 = 0; c2 = 0; n_unlock = 0;
    n_cmp++; if (bus3.locked !== 1'b1) begin n_err++; $display("FAIL badsel_pre_locked got=%b want=1", bus3.locked); end
    bus3.cfg_we  = 1'b1;
    bus3.cfg_sel = 2'd3;
    bus3.cfg_inc = 32'h0;
    tick();
    bus3.cfg_we  = 1'b0;
    n_cmp++; if (bus3.locked !== 1'b1) begin n_err++; $display("FAIL badsel_locked got=%b want=1", bus3.locked); end
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (bus3.ce[0] === 1'b1) c0++;
      if (bus3.ce[1] === 1'b1) c1++;
      if (bus3.ce[2] === 1'b1) c2++;
      if (bus3.locked !== 1'b1) n_unlock++;
    end
    n_cmp++; if (c0 !== 4) begin n_err++; $display("FAIL badsel_ce0 got=%0d want=4", c0); end
    n_cmp++; if (c1 !== 2) begin n_err++; $display("FAIL badsel_ce1 got=%0d want=2", c1); end
    n_cmp++; if (c2 !== 2) begin n_err++; $display("FAIL badsel_ce2 got=%0d want=2", c2); end
    n_cmp++; if (n_unlock !== 0) begin n_err++; $display("FAIL badsel_hold unlocked_cycles=%0d want=0", n_unlock); end
    $display("test_bad_sel: ce counts %0d/%0d/%0d", c0, c1, c2);
  endtask

  task automatic test_cfg_sync();
    logic [1:0] exp_ce;
    n_cmp++; if (bus4.locked !== 1'b1) begin n_err++; $display("FAIL cfgsync_pre_locked got=%b want=1", bus4.locked); end
    bus4.sync    = 1'b1;
    bus4.cfg_we  = 1'b1;
    bus4.cfg_sel = 2'd0;
    bus4.cfg_inc = INC_QTR;
    tick();
    bus4.sync    = 1'b0;
    bus4.cfg_we  = 1'b0;
    n_cmp++; if (bus4.ce !== 4'h0) begin n_err++; $display("FAIL cfgsync_ce got=%h want=0", bus4.ce); end
    n_cmp++; if (bus4.locked !== 1'b0) begin n_err++; $display("FAIL cfgsync_locked got=%b want=0", bus4.locked); end
    for (int j = 1; j <= 8; j++) begin
      tick();
      exp_ce = {(j % 4 == 2), (j % 4 == 0)};
      n_cmp++; if (bus4.ce[1:0] !== exp_ce) begin n_err++; $display("FAIL cfgsync_rate edge=%0d got=%b want=%b", j, bus4.ce[1:0], exp_ce); end
    end
    $display("test_cfg_sync: simultaneous write and sync checked");
  endtask

  task automatic test_rst_mid();
    logic [3:0] exp_ce;
    n_cmp++; if (bus4.locked !== 1'b0) begin n_err++; $display("FAIL rstmid_pre_locked got=%b want=0", bus4.locked); end
    rst          = 1'b1;
    bus4.cfg_we  = 1'b1;
    bus4.cfg_sel = 2'd2;
    bus4.cfg_inc = INC_2_5;
    bus4.sync    = 1'b1;
    bus4.ch_en   = 4'h0;
    tick();
    rst          = 1'b0;
    bus4.cfg_we  = 1'b0;
    bus4.sync    = 1'b0;
    bus4.ch_en   = 4'hF;
    n_cmp++; if (bus4.ce !== 4'h0) begin n_err++; $display("FAIL rstmid_ce got=%h want=0", bus4.ce); end
    n_cmp++; if (bus4.tgl !== 4'h0) begin n_err++; $display("FAIL rstmid_tgl got=%h want=0", bus4.tgl); end
    n_cmp++; if (bus4.locked !== 1'b0) begin n_err++; $display("FAIL rstmid_locked got=%b want=0", bus4.locked); end
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_ce = {(k % 2 == 0), 1'b0, (k % 4 == 2), (k % 2 == 0)};
      n_cmp++; if (bus4.ce !== exp_ce) begin n_err++; $display("FAIL rstmid_run_ce edge=%0d got=%h want=%h", k, bus4.ce, exp_ce); end
      n_cmp++; if (bus4.locked !== (k >= 16)) begin n_err++; $display("FAIL rstmid_run_locked edge=%0d got=%b want=%b", k, bus4.locked, (k >= 16)); end
    end
    $display("test_rst_mid: reset override checked");
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    rst          = 1'b1;
    bus4.ch_en   = 4'hF;
    bus4.sync    = 1'b0;
    bus4.cfg_we  = 1'b0;
    bus4.cfg_sel = '0;
    bus4.cfg_inc = '0;
    bus3.ch_en   = 3'h7;
    bus3.sync    = 1'b0;
    bus3.cfg_we  = 1'b0;
    bus3.cfg_sel = '0;
    bus3.cfg_inc = '0;
    #1;
    test_reset();
    test_cfg_rate();
    test_sync();
    test_ch_en();
    test_bad_sel();
    test_cfg_sync();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
